// File: rtl/csc_pkg.sv
// ---------------------------------------------------------------------------
// csc_pkg
// Shared definitions for the RGB->YCbCr colour-space converter.
//   csc_mode_e  : runtime matrix selection
//   CSC_COEF    : per-mode 3x3 coefficient table, rows Y/Cb/Cr, columns R/G/B,
//                 values scaled by 256 (Q8)
//   CSC_Y_OFS   : per-mode luma offset at 8-bit scale
//   CSC_C_OFS   : per-mode chroma offset at 8-bit scale
// Bypass is expressed as a unit permutation matrix (256 = 1.0) with zero
// offsets, so it shares the datapath and latency of the real matrices; the
// rounding constant is discarded by the shift, leaving the input unchanged.
// ---------------------------------------------------------------------------
package csc_pkg;

    typedef enum logic [1:0] {
        CSC_709L = 2'd0,
        CSC_601L = 2'd1,
        CSC_601F = 2'd2,
        CSC_BYP  = 2'd3
    } csc_mode_e;

    localparam int CSC_COEF [4][3][3] = '{
        '{ '{ 47,  157,  16}, '{-26,  -86, 112}, '{112, -102, -10} },
        '{ '{ 66,  129,  25}, '{-38,  -74, 112}, '{112,  -94, -18} },
        '{ '{ 77,  150,  29}, '{-43,  -85, 128}, '{128, -107, -21} },
        '{ '{  0,  256,   0}, '{  0,    0, 256}, '{256,    0,   0} }
    };

    localparam int CSC_Y_OFS [4] = '{16, 16, 0, 0};
    localparam int CSC_C_OFS [4] = '{128, 128, 128, 0};

endpackage

// File: rtl/csc_rgb2ycbcr_pipe_if.sv
// ---------------------------------------------------------------------------
// csc_rgb2ycbcr_pipe_if
// Pixel stream bundle with valid/ready handshake and video sideband.
//   valid, ready : beat handshake (transfer when both are high)
//   c0, c1, c2   : components; R/G/B on the input side, Y/Cb/Cr on the output
//   hs, vs, de   : sync sideband travelling with the pixel
// Modports: master drives the beat and samples ready, slave the reverse.
// ---------------------------------------------------------------------------
interface csc_rgb2ycbcr_pipe_if #(
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    logic [DW-1:0] c2;
    logic          hs;
    logic          vs;
    logic          de;

    modport master (output valid, c0, c1, c2, hs, vs, de, input ready);
    modport slave  (input valid, c0, c1, c2, hs, vs, de, output ready);
endinterface

// File: rtl/csc_dot3.sv
// ---------------------------------------------------------------------------
// csc_dot3
// One output channel of the converter: res = sat((c0*k0 + c1*k1 + c2*k2
// + offset + half) >>> FRAC). Four stages, all advancing on en_i:
//   S1 products and scaled offset, S2 pairwise sums, S3 final sum,
//   S4 shift/saturate into the output register.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   en_i                    : global pipeline enable (low = hold everything)
//   comp0_i..comp2_i        : unsigned components (R, G, B)
//   coef0_i..coef2_i        : signed Q(FRAC) coefficients for this beat
//   ofs_i                   : channel offset at 8-bit scale
//   res_o                   : registered, saturated result
// ---------------------------------------------------------------------------
module csc_dot3 #(
    parameter int DW   = 8,
    parameter int FRAC = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [DW-1:0]          comp0_i,
    input  logic [DW-1:0]          comp1_i,
    input  logic [DW-1:0]          comp2_i,
    input  logic signed [FRAC+1:0] coef0_i,
    input  logic signed [FRAC+1:0] coef1_i,
    input  logic signed [FRAC+1:0] coef2_i,
    input  logic [7:0]             ofs_i,
    output logic [DW-1:0]          res_o
);
    localparam int PW = DW + FRAC + 2;
    localparam int SW = DW + FRAC + 4;
    localparam logic signed [SW-1:0] ROUND = SW'(2 ** (FRAC - 1));

    logic signed [PW-1:0] prod0_d, prod1_d, prod2_d;
    logic signed [PW-1:0] prod0_q, prod1_q, prod2_q;
    logic signed [SW-1:0] ofs_d, ofs_q;
    logic signed [SW-1:0] sumA_d, sumB_d, sumA_q, sumB_q;
    logic signed [SW-1:0] sum_d, sum_q, shifted;
    logic [DW-1:0]        res_d, res_q;

    // Components are zero-extended to signed before multiplying, so a
    // negative coefficient never turns a large component into a negative one.
    always_comb begin
        prod0_d = PW'(signed'({1'b0, comp0_i})) * PW'(coef0_i);
        prod1_d = PW'(signed'({1'b0, comp1_i})) * PW'(coef1_i);
        prod2_d = PW'(signed'({1'b0, comp2_i})) * PW'(coef2_i);
        ofs_d   = signed'(SW'(ofs_i) << (DW - 8 + FRAC)) + ROUND;
        sumA_d  = SW'(prod0_q) + SW'(prod1_q);
        sumB_d  = SW'(prod2_q) + ofs_q;
        sum_d   = sumA_q + sumB_q;
    end

    // Arithmetic shift floors, which together with the half-LSB constant
    // gives round-half-up; the sign bit and the bits above DW drive clamping.
    assign shifted = sum_q >>> FRAC;

    always_comb begin
        res_d = shifted[DW-1:0];
        if (shifted[SW-1]) begin
            res_d = '0;
        end else if (|shifted[SW-2:DW]) begin
            res_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod0_q <= '0;
            prod1_q <= '0;
            prod2_q <= '0;
            ofs_q   <= '0;
            sumA_q  <= '0;
            sumB_q  <= '0;
            sum_q   <= '0;
            res_q   <= '0;
        end else if (en_i) begin
            prod0_q <= prod0_d;
            prod1_q <= prod1_d;
            prod2_q <= prod2_d;
            ofs_q   <= ofs_d;
            sumA_q  <= sumA_d;
            sumB_q  <= sumB_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/csc_rgb2ycbcr_pipe.sv
// ---------------------------------------------------------------------------
// csc_rgb2ycbcr_pipe
// Four-stage RGB->YCbCr converter with valid/ready backpressure. The whole
// pipeline shares one enable, so a stalled output freezes every stage and
// bubbles are never squeezed out.
// Ports:
//   clk, rst_n     : pixel clock, async active-low reset
//   mode_i         : requested matrix, taken only on a vs rising edge
//   active_mode_o  : matrix currently applied at the pipeline input
//   in_if (slave)  : R/G/B beats plus hs/vs/de
//   out_if (master): Y/Cb/Cr beats plus delayed hs/vs/de
// ---------------------------------------------------------------------------
module csc_rgb2ycbcr_pipe
    import csc_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode_i,
    output logic [1:0]           active_mode_o,
    csc_rgb2ycbcr_pipe_if.slave  in_if,
    csc_rgb2ycbcr_pipe_if.master out_if
);
    localparam int CW = FRAC + 2;

    logic                 en;
    logic                 accept;
    logic                 vsRise;
    csc_mode_e            activeMode_d, activeMode_q;
    logic                 prevVs_d, prevVs_q;
    logic [3:0]           valid_q, hs_q, vs_q, de_q;
    logic signed [CW-1:0] coef [3][3];
    logic [7:0]           ofs [3];
    logic [DW-1:0]        res [3];

    assign en          = !(out_if.valid && !out_if.ready);
    assign in_if.ready = en;
    assign accept      = in_if.valid && en;
    assign vsRise      = accept && in_if.vs && !prevVs_q;

    // The beat carrying the vs rising edge already uses the new matrix, so
    // coefficient selection looks at the next-state mode, not the register.
    always_comb begin
        activeMode_d = activeMode_q;
        prevVs_d     = prevVs_q;
        if (accept) begin
            prevVs_d = in_if.vs;
        end
        if (vsRise) begin
            activeMode_d = csc_mode_e'(mode_i);
        end
    end

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < 3; k++) begin
                coef[ch][k] = CW'(CSC_COEF[activeMode_d][ch][k]);
            end
        end
        ofs[0] = 8'(CSC_Y_OFS[activeMode_d]);
        ofs[1] = 8'(CSC_C_OFS[activeMode_d]);
        ofs[2] = 8'(CSC_C_OFS[activeMode_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            activeMode_q <= CSC_709L;
            prevVs_q     <= 1'b0;
        end else begin
            activeMode_q <= activeMode_d;
            prevVs_q     <= prevVs_d;
        end
    end

    // Valid and sideband shift in lockstep with the datapath stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            hs_q    <= '0;
            vs_q    <= '0;
            de_q    <= '0;
        end else if (en) begin
            valid_q <= {valid_q[2:0], in_if.valid};
            hs_q    <= {hs_q[2:0], in_if.hs};
            vs_q    <= {vs_q[2:0], in_if.vs};
            de_q    <= {de_q[2:0], in_if.de};
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        csc_dot3 #(
            .DW   (DW),
            .FRAC (FRAC)
        ) u_dot3 (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en),
            .comp0_i (in_if.c0),
            .comp1_i (in_if.c1),
            .comp2_i (in_if.c2),
            .coef0_i (coef[ch][0]),
            .coef1_i (coef[ch][1]),
            .coef2_i (coef[ch][2]),
            .ofs_i   (ofs[ch]),
            .res_o   (res[ch])
        );
    end

    assign out_if.valid  = valid_q[3];
    assign out_if.hs     = hs_q[3];
    assign out_if.vs     = vs_q[3];
    assign out_if.de     = de_q[3];
    assign out_if.c0     = res[0];
    assign out_if.c1     = res[1];
    assign out_if.c2     = res[2];
    assign active_mode_o = activeMode_q;

endmodule

// File: tb/tb_csc_rgb2ycbcr_pipe.sv
// ---------------------------------------------------------------------------
// tb_csc_rgb2ycbcr_pipe
// Bench for the colour-space converter: an 8-bit instance exercised through a
// scoreboard (expected Y/Cb/Cr and sideband queued at acceptance, popped when
// the output transfers) and a 10-bit instance for the wide-component path.
// ---------------------------------------------------------------------------
module tb_csc_rgb2ycbcr_pipe;

    localparam int COEF_TB [3][9] = '{
        '{ 47, 157,  16, -26, -86, 112, 112, -102, -10},
        '{ 66, 129,  25, -38, -74, 112, 112,  -94, -18},
        '{ 77, 150,  29, -43, -85, 128, 128, -107, -21}
    };
    localparam int Y_OFS_TB [3] = '{16, 16, 0};

    typedef struct {
        int         y;
        int         cb;
        int         cr;
        logic [2:0] sb;
        int         acceptCycle;
        bit         chkLat;
    } expBeat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode8 = 2'd0;
    logic [1:0] activeMode8;
    logic [1:0] mode10 = 2'd0;
    logic [1:0] activeMode10;

    int         vecCount = 0;
    int         missCount = 0;
    int         cycleCnt = 0;
    int         mActive = 0;
    bit         mPrevVs = 1'b0;
    expBeat_t   sbQueue[$];

    csc_rgb2ycbcr_pipe_if #(.DW(8))  inIf8 ();
    csc_rgb2ycbcr_pipe_if #(.DW(8))  outIf8 ();
    csc_rgb2ycbcr_pipe_if #(.DW(10)) inIf10 ();
    csc_rgb2ycbcr_pipe_if #(.DW(10)) outIf10 ();

    csc_rgb2ycbcr_pipe #(.DW(8), .FRAC(8)) dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_i        (mode8),
        .active_mode_o (activeMode8),
        .in_if         (inIf8),
        .out_if        (outIf8)
    );

    csc_rgb2ycbcr_pipe #(.DW(10), .FRAC(8)) dut10 (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_i        (mode10),
        .active_mode_o (activeMode10),
        .in_if         (inIf10),
        .out_if        (outIf10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Reference arithmetic: integer dot product, scaled offset, half-LSB
    // rounding, floor shift, clamp. Bypass is a plain channel permutation.
    function automatic int calc(input int dw, input int md, input int ch,
                                input int r, input int g, input int b);
        int s;
        int ofs;
        int mx;
        mx = (1 << dw) - 1;
        if (md == 3) begin
            return (ch == 0) ? g : ((ch == 1) ? b : r);
        end
        ofs = (ch == 0) ? Y_OFS_TB[md] : 128;
        s = COEF_TB[md][ch*3] * r + COEF_TB[md][ch*3+1] * g + COEF_TB[md][ch*3+2] * b
            + ofs * (1 << (dw - 8)) * 256 + 128;
        s = s >>> 8;
        if (s < 0) return 0;
        if (s > mx) return mx;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Present one beat on the 8-bit instance and hold it until it is taken.
    // The expected result is queued once in_ready is seen high half a cycle
    // before the accepting edge.
    task automatic applyStimulus(input int r, input int g, input int b,
                                 input bit hs, input bit vs, input bit de,
                                 input int md, input bit rndReady);
        expBeat_t e;
        int       tries = 0;
        bit       done = 1'b0;
        while (!done) begin
            @(negedge clk);
            outIf8.ready = rndReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            inIf8.valid  = 1'b1;
            inIf8.c0     = 8'(r);
            inIf8.c1     = 8'(g);
            inIf8.c2     = 8'(b);
            inIf8.hs     = hs;
            inIf8.vs     = vs;
            inIf8.de     = de;
            mode8        = 2'(md);
            #1;
            if (inIf8.ready) begin
                if (vs && !mPrevVs) mActive = md;
                mPrevVs       = vs;
                e.y           = calc(8, mActive, 0, r, g, b);
                e.cb          = calc(8, mActive, 1, r, g, b);
                e.cr          = calc(8, mActive, 2, r, g, b);
                e.sb          = {hs, vs, de};
                e.acceptCycle = cycleCnt;
                e.chkLat      = !rndReady;
                sbQueue.push_back(e);
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 200) begin
                    checkOutput("accept_timeout", 64'd0, 64'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idleCycle(input bit rndReady);
        @(negedge clk);
        inIf8.valid  = 1'b0;
        outIf8.ready = rndReady ? ($urandom_range(0, 1) != 0) : 1'b1;
    endtask

    task automatic checkMode(input string tag);
        @(posedge clk);
        #1;
        checkOutput(tag, 64'(activeMode8), 64'(mActive));
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        inIf8.valid  = 1'b0;
        outIf8.ready = 1'b1;
        while (sbQueue.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 64'(sbQueue.size()), 64'd0);
    endtask

    // Output side: sampled after the bench has updated out_ready for the
    // coming edge. A transfer pops the scoreboard; a stall arms a check that
    // everything visible is unchanged one cycle later.
    initial begin : monitor
        logic [27:0] heldVec;
        logic [27:0] nowVec;
        bit          wasStalled;
        expBeat_t    e;
        wasStalled = 1'b0;
        heldVec    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                wasStalled = 1'b0;
            end else begin
                nowVec = {outIf8.valid, outIf8.c0, outIf8.c1, outIf8.c2,
                          outIf8.hs, outIf8.vs, outIf8.de};
                if (wasStalled) checkOutput("stall_hold", 64'(nowVec), 64'(heldVec));
                if (outIf8.valid && outIf8.ready) begin
                    if (sbQueue.size() == 0) begin
                        checkOutput("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = sbQueue.pop_front();
                        checkOutput("y", 64'(outIf8.c0), 64'(e.y));
                        checkOutput("cb", 64'(outIf8.c1), 64'(e.cb));
                        checkOutput("cr", 64'(outIf8.c2), 64'(e.cr));
                        checkOutput("sideband", 64'({outIf8.hs, outIf8.vs, outIf8.de}), 64'(e.sb));
                        if (e.chkLat) checkOutput("latency", 64'(cycleCnt - e.acceptCycle), 64'd4);
                    end
                end
                wasStalled = outIf8.valid && !outIf8.ready;
                heldVec    = nowVec;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        inIf8.valid = 1'b0;  inIf8.c0 = '0;  inIf8.c1 = '0;  inIf8.c2 = '0;
        inIf8.hs = 1'b0;     inIf8.vs = 1'b0; inIf8.de = 1'b0;
        outIf8.ready = 1'b1;
        inIf10.valid = 1'b0; inIf10.c0 = '0; inIf10.c1 = '0; inIf10.c2 = '0;
        inIf10.hs = 1'b0;    inIf10.vs = 1'b0; inIf10.de = 1'b0;
        outIf10.ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 64'(outIf8.valid), 64'd0);
        checkOutput("rst_in_ready", 64'(inIf8.ready), 64'd1);
        checkOutput("rst_out_data", 64'({outIf8.c0, outIf8.c1, outIf8.c2}), 64'd0);
        checkOutput("rst_out_sb", 64'({outIf8.hs, outIf8.vs, outIf8.de}), 64'd0);
        checkOutput("rst_active_mode", 64'(activeMode8), 64'd0);
        checkOutput("rst_out_valid10", 64'(outIf10.valid), 64'd0);
        rst_n = 1'b1;

        $display("[TB] mode 0 white/black");
        applyStimulus(255, 255, 255, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        drain();

        $display("[TB] mode switching on vs edges");
        applyStimulus(0, 0, 255, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        checkMode("mode_latch_601f");
        applyStimulus(255, 0, 0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        applyStimulus(0, 255, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        checkMode("mode_hold_midframe");
        applyStimulus(0, 255, 0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus(0, 255, 0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        checkMode("mode_latch_601l");
        applyStimulus(10, 20, 30, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        checkMode("mode_hold_midframe2");
        applyStimulus(10, 20, 30, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        checkMode("mode_latch_bypass");
        applyStimulus(200, 100, 50, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        drain();

        $display("[TB] 64-beat ramp with random backpressure");
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) idleCycle(1'b1);
            applyStimulus((i * 4) & 255, 255 - i * 4, (i * 3) & 255,
                          (i % 8) == 0, i == 0, 1'($urandom_range(0, 1)),
                          (i == 0) ? 0 : int'($urandom_range(0, 3)), 1'b1);
        end
        drain();

        $display("[TB] 10-bit white");
        @(negedge clk);
        inIf10.valid = 1'b1;
        inIf10.c0 = 10'd1023; inIf10.c1 = 10'd1023; inIf10.c2 = 10'd1023;
        inIf10.de = 1'b1;
        #1;
        checkOutput("in_ready10", 64'(inIf10.ready), 64'd1);
        @(negedge clk);
        inIf10.valid = 1'b0;
        n = 0;
        while (!outIf10.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid10", 64'(outIf10.valid), 64'd1);
        checkOutput("y10", 64'(outIf10.c0), 64'(calc(10, 0, 0, 1023, 1023, 1023)));
        checkOutput("cb10", 64'(outIf10.c1), 64'(calc(10, 0, 1, 1023, 1023, 1023)));
        checkOutput("cr10", 64'(outIf10.c2), 64'(calc(10, 0, 2, 1023, 1023, 1023)));

        $display("[TB] reset mid-stream");
        applyStimulus(255, 255, 255, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        applyStimulus(100, 50, 25, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        applyStimulus(7, 8, 9, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        applyStimulus(90, 180, 45, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        applyStimulus(33, 66, 99, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        inIf8.valid = 1'b0;
        sbQueue.delete();
        mActive = 0;
        mPrevVs = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(outIf8.valid), 64'd0);
        checkOutput("midrst_out_data", 64'({outIf8.c0, outIf8.c1, outIf8.c2}), 64'd0);
        checkOutput("midrst_out_sb", 64'({outIf8.hs, outIf8.vs, outIf8.de}), 64'd0);
        checkOutput("midrst_in_ready", 64'(inIf8.ready), 64'd1);
        checkOutput("midrst_active_mode", 64'(activeMode8), 64'd0);
        checkOutput("midrst_y10", 64'(outIf10.c0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(255, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        checkMode("mode_after_reset");
        applyStimulus(0, 0, 255, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        checkMode("mode_latch_after_reset");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
